// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator for a registered 4-bit ALU.
// Screens illegal commands, holds operands for the ALU latency, captures results
// into a first-word-fall-through response FIFO tagged with opcode and error flag.
module alu_cmd_issuer #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_op,
  output logic       rsp_err,
  output logic       busy
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned COUNT_W = PTR_W + 1;
  localparam logic [2:0]  OP_MUL  = 3'd4;
  localparam logic [2:0]  OP_DIV  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         alu_a_q, alu_a_d;
  logic [3:0]         alu_b_q, alu_b_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [2:0]         err_op_q, err_op_d;

  logic               accept_c;
  logic               legal_c;
  logic               push_c;
  logic [7:0]         push_data_c;
  logic [2:0]         push_op_c;
  logic               push_err_c;
  logic               pop_c;

  logic [7:0]         mem_data [FIFO_DEPTH];
  logic [2:0]         mem_op   [FIFO_DEPTH];
  logic               mem_err  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [COUNT_W-1:0] count_q;

  // Handshake and legality screening (divide-by-zero and opcodes 6/7 never reach the ALU)
  assign cmd_ready = (state_q == ST_IDLE) && (count_q < COUNT_W'(FIFO_DEPTH));
  assign accept_c  = cmd_valid && cmd_ready;
  assign legal_c   = (cmd_op <= OP_MUL) || ((cmd_op == OP_DIV) && (cmd_b != 4'd0));
  assign busy      = (state_q != ST_IDLE);

  // Next-state, operand hold and response push generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    err_op_d    = err_op_q;
    push_c      = 1'b0;
    push_data_c = 8'h00;
    push_op_c   = 3'd0;
    push_err_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (legal_c) begin
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
            alu_op_d = cmd_op;
            cnt_d    = CNT_W'(LATENCY);
            state_d  = ST_WAIT;
          end else begin
            err_op_d = cmd_op;
            state_d  = ST_ERR;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          push_c      = 1'b1;
          push_data_c = alu_result;
          push_op_c   = alu_op_q;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ERR: begin
        push_c     = 1'b1;
        push_op_c  = err_op_q;
        push_err_c = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, wait counter and registered ALU bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      err_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      err_op_q <= err_op_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

  // Response FIFO: pop of an empty FIFO is ignored; push into full cannot happen
  assign pop_c = rsp_ready && (count_q != '0);

  // FIFO storage; contents are only meaningful below count, so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem_data[wr_ptr_q] <= push_data_c;
      mem_op[wr_ptr_q]   <= push_op_c;
      mem_err[wr_ptr_q]  <= push_err_c;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + COUNT_W'(1);
        2'b01:   count_q <= count_q - COUNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry presented directly from storage, zeroed while empty
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr_q] : 8'h00;
  assign rsp_op    = rsp_valid ? mem_op[rd_ptr_q]   : 3'd0;
  assign rsp_err   = rsp_valid ? mem_err[rd_ptr_q]  : 1'b0;

endmodule
